// File: rtl/motion_pkg.sv
// Shared types and width helpers for the object motion engine.
package motion_pkg;

    localparam int WIDTH_DEF   = 640;
    localparam int HEIGHT_DEF  = 480;
    localparam int FRAC_DEF    = 8;
    localparam int V_W_DEF     = 12;
    localparam int NUM_OBJ_DEF = 8;

    function automatic int coord_w(input int extent);
        return $clog2(extent);
    endfunction

    function automatic int pos_w(input int extent, input int frac);
        return $clog2(extent) + frac;
    endfunction

    function automatic int idx_w(input int num_obj);
        return $clog2(num_obj);
    endfunction

    localparam int X_PW_DEF = pos_w(WIDTH_DEF, FRAC_DEF);
    localparam int Y_PW_DEF = pos_w(HEIGHT_DEF, FRAC_DEF);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } fsm_t;

    // Slot layout for the default screen geometry.
    typedef struct packed {
        logic                      alive;
        logic [X_PW_DEF-1:0]       x;
        logic [Y_PW_DEF-1:0]       y;
        logic signed [V_W_DEF-1:0] vx;
        logic signed [V_W_DEF-1:0] vy;
    } obj_state_t;

endpackage

// File: rtl/motion_wrap_axis.sv
// One axis of the integrator: fixed-point pos + vel with toroidal wrap onto [0, P).
module motion_wrap_axis #(
    parameter int P    = 640,
    parameter int PW   = 10,
    parameter int FRAC = 8,
    parameter int V_W  = 12
) (
    input  logic [PW+FRAC-1:0]   pos,
    input  logic signed [V_W-1:0] vel,
    output logic [PW+FRAC-1:0]   pos_nxt
);

    localparam int T_W = PW + FRAC + 2;
    localparam logic [T_W-FRAC-1:0] P_INT = (T_W-FRAC)'(P);
    localparam logic signed [T_W-1:0] SPAN = $signed({P_INT, {FRAC{1'b0}}});

    // Velocity is bounded below one screen span, so a single correction always lands in range.
    function automatic logic [PW+FRAC-1:0] wrap_add(input logic [PW+FRAC-1:0]   p,
                                                    input logic signed [V_W-1:0] v);
        logic signed [T_W-1:0] t;
        logic signed [T_W-1:0] r;
        t = $signed({2'b00, p}) + $signed({{(T_W-V_W){v[V_W-1]}}, v});
        if (t[T_W-1])
            r = t + SPAN;
        else if (t[T_W-1:FRAC] >= P_INT)
            r = t - SPAN;
        else
            r = t;
        return r[PW+FRAC-1:0];
    endfunction

    assign pos_nxt = wrap_add(pos, vel);

endmodule

// File: rtl/obj_motion_engine.sv
// Time-multiplexed position/velocity integrator for NUM_OBJ screen objects, one slot per clock.
// Optional velocity drag is enabled by defining OBJ_DRAG_EN.
module obj_motion_engine
    import motion_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int NUM_OBJ    = 8,
    parameter int FRAC       = 8,
    parameter int V_W        = 12,
    parameter int DRAG_SHIFT = 6
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                tick,
    input  logic                                ld_valid,
    input  logic                                ld_kill,
    input  logic [idx_w(NUM_OBJ)-1:0]           ld_idx,
    input  logic [pos_w(WIDTH, FRAC)-1:0]       ld_x,
    input  logic [pos_w(HEIGHT, FRAC)-1:0]      ld_y,
    input  logic signed [V_W-1:0]               ld_vx,
    input  logic signed [V_W-1:0]               ld_vy,
    input  logic [idx_w(NUM_OBJ)-1:0]           rd_idx,
    output logic [coord_w(WIDTH)-1:0]           rd_x,
    output logic [coord_w(HEIGHT)-1:0]          rd_y,
    output logic                                rd_alive,
    output logic                                busy,
    output logic                                sweep_done,
    output logic                                tick_ovr
);

    localparam int IDX_W = idx_w(NUM_OBJ);
    localparam int X_W   = coord_w(WIDTH);
    localparam int Y_W   = coord_w(HEIGHT);
    localparam int XP_W  = X_W + FRAC;
    localparam int YP_W  = Y_W + FRAC;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OBJ - 1);

    typedef struct packed {
        logic                  alive;
        logic [XP_W-1:0]       x;
        logic [YP_W-1:0]       y;
        logic signed [V_W-1:0] vx;
        logic signed [V_W-1:0] vy;
    } slot_t;

    slot_t                 slots [NUM_OBJ];
    slot_t                 cur;
    fsm_t                  state;
    logic [IDX_W-1:0]      ptr;
    logic                  pending;
    logic [XP_W-1:0]       x_nxt;
    logic [YP_W-1:0]       y_nxt;
    logic signed [V_W-1:0] vx_nxt;
    logic signed [V_W-1:0] vy_nxt;
    logic                  sweep_wr;

    // Small velocities still decay by one LSB so they reach exactly zero.
    function automatic logic signed [V_W-1:0] drag_step(input logic signed [V_W-1:0] v);
        logic signed [V_W-1:0] d;
        d = v >>> DRAG_SHIFT;
        if (d == '0 && v != '0)
            return v[V_W-1] ? v + V_W'(1) : v - V_W'(1);
        return v - d;
    endfunction

    assign cur = slots[ptr];

    motion_wrap_axis #(.P(WIDTH), .PW(X_W), .FRAC(FRAC), .V_W(V_W)) u_wrap_x (
        .pos     (cur.x),
        .vel     (cur.vx),
        .pos_nxt (x_nxt)
    );

    motion_wrap_axis #(.P(HEIGHT), .PW(Y_W), .FRAC(FRAC), .V_W(V_W)) u_wrap_y (
        .pos     (cur.y),
        .vel     (cur.vy),
        .pos_nxt (y_nxt)
    );

    always_comb begin
        vx_nxt = cur.vx;
        vy_nxt = cur.vy;
`ifdef OBJ_DRAG_EN
        vx_nxt = drag_step(cur.vx);
        vy_nxt = drag_step(cur.vy);
`endif
    end

    // A load to the slot under the sweep pointer wins; the sweep result is dropped.
    assign sweep_wr = (state == SWEEP) && cur.alive && !(ld_valid && ld_idx == ptr);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_OBJ; i++)
                slots[i] <= '0;
            state      <= IDLE;
            ptr        <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            tick_ovr   <= 1'b0;
            rd_x       <= '0;
            rd_y       <= '0;
            rd_alive   <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick || pending) begin
                        state   <= SWEEP;
                        ptr     <= '0;
                        busy    <= 1'b1;
                        pending <= pending && tick;
                    end
                end
                SWEEP: begin
                    if (ptr == LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        sweep_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (tick && state != IDLE) begin
                if (pending)
                    tick_ovr <= 1'b1;
                else
                    pending <= 1'b1;
            end

            if (sweep_wr)
                slots[ptr] <= '{alive: 1'b1, x: x_nxt, y: y_nxt, vx: vx_nxt, vy: vy_nxt};

            if (ld_valid) begin
                if (ld_kill)
                    slots[ld_idx].alive <= 1'b0;
                else
                    slots[ld_idx] <= '{alive: 1'b1, x: ld_x, y: ld_y, vx: ld_vx, vy: ld_vy};
            end

            rd_x     <= slots[rd_idx].x[XP_W-1:FRAC];
            rd_y     <= slots[rd_idx].y[YP_W-1:FRAC];
            rd_alive <= slots[rd_idx].alive;
        end
    end

endmodule

// File: tb/tb_obj_motion_engine.sv
// Directed bench for obj_motion_engine with a slot-level reference model checked every cycle.
module tb_obj_motion_engine;

    localparam int NOBJ = 8;
    localparam int FR   = 8;
    localparam int W    = 640;
    localparam int H    = 480;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               tick = 1'b0;
    logic               ld_valid = 1'b0;
    logic               ld_kill = 1'b0;
    logic [2:0]         ld_idx = '0;
    logic [17:0]        ld_x = '0;
    logic [16:0]        ld_y = '0;
    logic signed [11:0] ld_vx = '0;
    logic signed [11:0] ld_vy = '0;
    logic [2:0]         rd_idx = '0;
    logic [9:0]         rd_x;
    logic [8:0]         rd_y;
    logic               rd_alive;
    logic               busy;
    logic               sweep_done;
    logic               tick_ovr;

    obj_motion_engine dut (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (tick),
        .ld_valid   (ld_valid),
        .ld_kill    (ld_kill),
        .ld_idx     (ld_idx),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_vx      (ld_vx),
        .ld_vy      (ld_vy),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_alive   (rd_alive),
        .busy       (busy),
        .sweep_done (sweep_done),
        .tick_ovr   (tick_ovr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-slot fixed-point state plus which slot the sweep visits next
    // (-1 idle, 0..NOBJ-1 visiting that slot, NOBJ = done cycle).
    int mx [NOBJ];
    int my [NOBJ];
    int mvx [NOBJ];
    int mvy [NOBJ];
    bit mal [NOBJ];
    int m_phase = -1;
    bit m_pend = 0;
    bit m_ovr = 0;
    int e_rdx = 0;
    int e_rdy = 0;
    bit e_al = 0;
    int done_cnt = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input int t, input int span);
        if (t < 0) return t + span;
        if (t >= span) return t - span;
        return t;
    endfunction

    function automatic int drag(input int v);
        int d;
        d = v >>> 6;
        if (v != 0 && d == 0) return (v > 0) ? v - 1 : v + 1;
        return v - d;
    endfunction

    task automatic step();
        int k;
        if (!resetN) begin
            for (int i = 0; i < NOBJ; i++) begin
                mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mal[i] = 0;
            end
            m_phase = -1; m_pend = 0; m_ovr = 0;
            e_rdx = 0; e_rdy = 0; e_al = 0;
        end else begin
            e_rdx = mx[rd_idx] >> FR;
            e_rdy = my[rd_idx] >> FR;
            e_al  = mal[rd_idx];
            if (m_phase >= 0 && m_phase < NOBJ) begin
                k = m_phase;
                if (mal[k] && !(ld_valid && int'(ld_idx) == k)) begin
                    mx[k] = wrap(mx[k] + mvx[k], W << FR);
                    my[k] = wrap(my[k] + mvy[k], H << FR);
`ifdef OBJ_DRAG_EN
                    mvx[k] = drag(mvx[k]);
                    mvy[k] = drag(mvy[k]);
`endif
                end
            end
            if (ld_valid) begin
                if (ld_kill) mal[ld_idx] = 0;
                else begin
                    mal[ld_idx] = 1; mx[ld_idx] = int'(ld_x); my[ld_idx] = int'(ld_y);
                    mvx[ld_idx] = int'(ld_vx); mvy[ld_idx] = int'(ld_vy);
                end
            end
            if (m_phase < 0) begin
                if (tick || m_pend) begin
                    m_pend  = m_pend && tick;
                    m_phase = 0;
                end
            end else begin
                if (tick) begin
                    if (m_pend) m_ovr = 1;
                    else m_pend = 1;
                end
                m_phase = (m_phase == NOBJ) ? -1 : m_phase + 1;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_x", int'(rd_x), e_rdx);
        chk("rd_y", int'(rd_y), e_rdy);
        chk("rd_alive", int'(rd_alive), int'(e_al));
        chk("busy", int'(busy), (m_phase >= 0 && m_phase < NOBJ) ? 1 : 0);
        chk("sweep_done", int'(sweep_done), (m_phase == NOBJ) ? 1 : 0);
        chk("tick_ovr", int'(tick_ovr), int'(m_ovr));
        if (sweep_done) done_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int idx, input int x, input int y, input int vx, input int vy);
        ld_valid = 1'b1; ld_kill = 1'b0; ld_idx = 3'(idx);
        ld_x = 18'(x); ld_y = 17'(y); ld_vx = 12'(vx); ld_vy = 12'(vy);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_phase(input int target, input string name);
        int n;
        n = 0;
        while (m_phase != target && n < 20) begin
            step();
            n++;
        end
        chk(name, m_phase, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        run(2);
        resetN = 1'b1;
        run(2);

        // Basic integration with subpixel carry.
        load(0, 100 << FR, 0, 'h280, 0);
        pulse_tick();
        run(10);
        rd_idx = 3'd0;
        step();
        chk("t1_rd_x", int'(rd_x), 102);
        chk("t1_model_x", mx[0], 26240);

        // Wrap in both directions.
        load(1, 639 << FR, 0, 384, 0);
        load(2, 0, 64, 0, -128);
        pulse_tick();
        run(10);
        rd_idx = 3'd1;
        step();
        chk("t2_rd_x_wrap", int'(rd_x), 0);
        chk("t2_model_x", mx[1], 128);
        rd_idx = 3'd2;
        step();
        chk("t2_rd_y_wrap", int'(rd_y), 479);
        chk("t2_model_y", my[2], 122816);

        // Pending tick, then a dropped tick.
        done_cnt = 0;
        pulse_tick();
        step();
        pulse_tick();
        chk("t3_no_ovr_yet", int'(tick_ovr), 0);
        step();
        pulse_tick();
        run(30);
        chk("t3_done_pulses", done_cnt, 2);
        chk("t3_ovr", int'(tick_ovr), 1);

        // Load collision at the sweep pointer, and a killed slot.
        load(4, 50 << FR, 10 << FR, 256, 0);
        ld_valid = 1'b1; ld_kill = 1'b1; ld_idx = 3'd4;
        step();
        ld_valid = 1'b0; ld_kill = 1'b0;
        load(3, 10 << FR, 10 << FR, 256, 256);
        pulse_tick();
        wait_phase(3, "t4_reach_ptr3");
        load(3, (300 << FR) + 'h12, 200 << FR, -5, 7);
        run(10);
        rd_idx = 3'd3;
        step();
        chk("t4_rd_x_loaded", int'(rd_x), 300);
        chk("t4_model_x", mx[3], 76818);
        rd_idx = 3'd4;
        step();
        chk("t4_dead_alive", int'(rd_alive), 0);
        chk("t4_dead_x", int'(rd_x), 50);

        // Reset mid-sweep.
        pulse_tick();
        wait_phase(5, "t5_reach_ptr5");
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_ovr", int'(tick_ovr), 0);
        chk("t5_rd_x", int'(rd_x), 0);
        for (int i = 0; i < NOBJ; i++) begin
            rd_idx = 3'(i);
            step();
            chk("t5_slot_dead", int'(rd_alive), 0);
        end
        busy_cnt = 0;
        done_cnt = 0;
        pulse_tick();
        run(12);
        chk("t5_busy_cycles", busy_cnt, 8);
        chk("t5_done_pulses", done_cnt, 1);

        // Velocity evolution.
        load(6, 0, 0, 64, 0);
        load(7, 0, 0, -1, 0);
        pulse_tick();
        run(10);
`ifdef OBJ_DRAG_EN
        chk("t6_drag_64", mvx[6], 63);
        chk("t6_drag_m1", mvx[7], 0);
`else
        chk("t6_const_64", mvx[6], 64);
        chk("t6_const_m1", mvx[7], -1);
`endif
        pulse_tick();
        run(10);
`ifdef OBJ_DRAG_EN
        chk("t6_drag_zero_stays", mvx[7], 0);
        chk("t6_drag_63", mvx[6], 62);
`else
        chk("t6_model_x7", mx[7], (W << FR) - 2);
`endif
        rd_idx = 3'd7;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
